// File: rtl/recording_playback_sequencer.sv
// -----------------------------------------------------------------------------
// recording_playback_sequencer
//
// Replays the note list held in the recording store as a timed sequence of
// frequency codes. Each stored entry is {duration[17:10], frequency[9:0]},
// with the duration counted in ticks of CLK_100hz (10 ms each).
//
// Ports
//   CLK_100hz        in   100 Hz tick clock
//   systemReset_n    in   asynchronous active-low reset
//   start_n          in   active-low playback request, falling edge triggers
//   stop_n           in   active-low abort, level sensitive
//   entryCount       in   number of valid entries, latched at start
//   mem_readAddress  out  entry index being fetched
//   mem_readRequest  out  one-cycle read strobe
//   mem_readValid    in   read data valid
//   mem_readData     in   {duration, frequency} of the fetched entry
//   outputFrequency  out  code to the signal generator, 0 = silence
//   isPlaying        out  high while fetching or holding a note
//   playbackComplete out  one-cycle pulse at normal end of the list
//   readError        out  sticky read timeout flag, cleared by next start
//
// Read handshake: the sequencer raises mem_readRequest for exactly one cycle
// with mem_readAddress valid, then holds the address and waits for a single
// cycle of mem_readValid carrying the entry. A valid seen at any other time
// is ignored; no valid within TIMEOUT_TICKS waiting cycles is a read fault.
// -----------------------------------------------------------------------------
module recording_playback_sequencer #(
   parameter int ADDR_WIDTH    = 8,
   parameter int TIMEOUT_TICKS = 4
) (
   input  logic                  CLK_100hz,
   input  logic                  systemReset_n,
   input  logic                  start_n,
   input  logic                  stop_n,
   input  logic [ADDR_WIDTH:0]   entryCount,
   output logic [ADDR_WIDTH-1:0] mem_readAddress,
   output logic                  mem_readRequest,
   input  logic                  mem_readValid,
   input  logic [17:0]           mem_readData,
   output logic [9:0]            outputFrequency,
   output logic                  isPlaying,
   output logic                  playbackComplete,
   output logic                  readError
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] MAX_COUNT = CW'(1) << ADDR_WIDTH;
   localparam int WW = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [WW-1:0] TIMEOUT_LIM = WW'(TIMEOUT_TICKS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic                  start_prev_q;
   logic [CW-1:0]         count_q, count_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            dur_q, dur_d;
   logic [WW-1:0]         wait_q, wait_d;
   logic [9:0]            freq_q, freq_d;
   logic                  error_q, error_d;
   logic                  req_q, playing_q, complete_q;

   logic                  start_fire;
   logic                  advance;
   logic [CW-1:0]         addr_next;

   assign start_fire = start_prev_q & ~start_n;
   assign addr_next  = {1'b0, addr_q} + CW'(1);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      addr_d  = addr_q;
      dur_d   = dur_q;
      wait_d  = wait_q;
      freq_d  = freq_q;
      error_d = error_q;
      advance = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_fire && stop_n) begin
               // Counts beyond the store depth are clamped to the store depth.
               count_d = entryCount[ADDR_WIDTH] ? MAX_COUNT : entryCount;
               error_d = 1'b0;
               if (entryCount == '0) begin
                  state_d = S_DONE;
               end else begin
                  addr_d  = '0;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            wait_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_readValid) begin
               freq_d = mem_readData[9:0];
               dur_d  = mem_readData[17:10];
               if (mem_readData[17:10] == 8'd0) begin
                  advance = 1'b1;
               end else begin
                  state_d = S_HOLD;
               end
            end else if (wait_q + WW'(1) == TIMEOUT_LIM) begin
               error_d = 1'b1;
               freq_d  = '0;
               state_d = S_IDLE;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         S_HOLD: begin
            dur_d = dur_q - 8'd1;
            if (dur_q == 8'd1) begin
               advance = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (advance) begin
         if (addr_next == count_q) begin
            state_d = S_DONE;
         end else begin
            addr_d  = addr_next[ADDR_WIDTH-1:0];
            state_d = S_REQ;
         end
      end

      // Abort overrides everything decided above, including a timeout.
      if (!stop_n && state_q != S_IDLE) begin
         state_d = S_IDLE;
         addr_d  = addr_q;
         freq_d  = '0;
         error_d = error_q;
      end

      // The completion cycle is always silent.
      if (state_d == S_DONE) begin
         freq_d = '0;
      end
   end

   always_ff @(posedge CLK_100hz or negedge systemReset_n) begin
      if (!systemReset_n) begin
         state_q      <= S_IDLE;
         start_prev_q <= 1'b1;
         count_q      <= '0;
         addr_q       <= '0;
         dur_q        <= '0;
         wait_q       <= '0;
         freq_q       <= '0;
         error_q      <= 1'b0;
         req_q        <= 1'b0;
         playing_q    <= 1'b0;
         complete_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_prev_q <= start_n;
         count_q      <= count_d;
         addr_q       <= addr_d;
         dur_q        <= dur_d;
         wait_q       <= wait_d;
         freq_q       <= freq_d;
         error_q      <= error_d;
         // Status outputs are registered from the next state so they line up
         // with the state they describe.
         req_q        <= (state_d == S_REQ);
         playing_q    <= (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_HOLD);
         complete_q   <= (state_d == S_DONE);
      end
   end

   assign mem_readAddress  = addr_q;
   assign mem_readRequest  = req_q;
   assign outputFrequency  = freq_q;
   assign isPlaying        = playing_q;
   assign playbackComplete = complete_q;
   assign readError        = error_q;

endmodule

// File: tb/tb_recording_playback_sequencer.sv
module tb_recording_playback_sequencer;

   localparam int AW = 8;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_n = 1'b1;
   logic          stop_n = 1'b1;
   logic [AW:0]   entry_count = '0;
   logic          mem_valid = 1'b0;
   logic [17:0]   mem_data = '0;
   logic [AW-1:0] mem_addr;
   logic          mem_req;
   logic [9:0]    out_freq;
   logic          is_playing;
   logic          complete;
   logic          read_error;

   always #5 clk = ~clk;

   recording_playback_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT_TICKS(4)) dut (
      .CLK_100hz       (clk),
      .systemReset_n   (rst_n),
      .start_n         (start_n),
      .stop_n          (stop_n),
      .entryCount      (entry_count),
      .mem_readAddress (mem_addr),
      .mem_readRequest (mem_req),
      .mem_readValid   (mem_valid),
      .mem_readData    (mem_data),
      .outputFrequency (out_freq),
      .isPlaying       (is_playing),
      .playbackComplete(complete),
      .readError       (read_error)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   // record: {err, complete, playing, req, chk_addr, addr[7:0], freq[9:0]}
   logic [22:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- memory model ----------------
   logic [7:0] mem_dur[256];
   logic [9:0] mem_frq[256];
   int         mem_lat[256];  // cycles from request to valid; 0 = never answers
   int         rem = 0;
   int         pend_addr = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         mem_valid = 1'b0;
         if (rem > 0) begin
            rem--;
            if (rem == 0) begin
               mem_valid = 1'b1;
               mem_data  = {mem_dur[pend_addr], mem_frq[pend_addr]};
            end
         end
         @(negedge clk);
         if (mem_req === 1'b1) begin
            pend_addr = int'(mem_addr);
            rem       = mem_lat[pend_addr];
         end
      end
   end

   task automatic set_entry(input int i, input int d, input int f, input int l);
      mem_dur[i] = d[7:0];
      mem_frq[i] = f[9:0];
      mem_lat[i] = l;
   endtask

   // ---------------- reference timeline ----------------
   function automatic void push(input logic [9:0] f, input logic rq, input logic ca,
                                input logic [7:0] a, input logic pl, input logic cp,
                                input logic er);
      exp_q.push_back({er, cp, pl, rq, ca, a, f});
   endfunction

   // Expected per-cycle outputs, cycle 0 being the cycle after the start is
   // sampled: each entry is 1 request cycle, L waiting cycles and D cycles of
   // its note; the previous note keeps sounding while the next is fetched.
   task automatic build(input int cnt);
      int n;
      logic [9:0] cur;
      exp_q.delete();
      n = (cnt > 256) ? 256 : cnt;
      cur = '0;
      for (int i = 0; i < n; i++) begin
         push(cur, 1'b1, 1'b1, i[7:0], 1'b1, 1'b0, 1'b0);
         if (mem_lat[i] == 0) begin
            repeat (4) push(cur, 1'b0, 1'b1, i[7:0], 1'b1, 1'b0, 1'b0);
            push(10'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
            return;
         end
         repeat (mem_lat[i]) push(cur, 1'b0, 1'b1, i[7:0], 1'b1, 1'b0, 1'b0);
         cur = mem_frq[i];
         repeat (int'(mem_dur[i])) push(cur, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      end
      push(10'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      push(10'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic compare(input int k, input logic [22:0] r);
      check($sformatf("freq@%0d", k), 32'(out_freq), 32'(r[9:0]));
      check($sformatf("req@%0d", k), 32'(mem_req), 32'(r[19]));
      check($sformatf("playing@%0d", k), 32'(is_playing), 32'(r[20]));
      check($sformatf("complete@%0d", k), 32'(complete), 32'(r[21]));
      check($sformatf("error@%0d", k), 32'(read_error), 32'(r[22]));
      if (r[18]) check($sformatf("addr@%0d", k), 32'(mem_addr), 32'(r[17:10]));
   endtask

   // ---------------- driver ----------------
   // stop_at: cycle index to pull stop_n low (-1 none, -2 random)
   task automatic run(input int cnt, input int stop_at, input int hold_low);
      int s;
      logic [22:0] last_r;
      entry_count = cnt[AW:0];
      build(cnt);
      s = stop_at;
      if (s == -2) s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, exp_q.size() - 1)) : -1;
      if (s >= 0 && s < exp_q.size() && (exp_q[s][20] || exp_q[s][21])) begin
         while (exp_q.size() > s + 1) void'(exp_q.pop_back());
         repeat (2) push(10'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      end else begin
         s = -1;
      end
      last_r = exp_q[exp_q.size() - 1];
      while (exp_q.size() < hold_low + 2) push(10'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, last_r[22]);
      @(posedge clk);
      #1 start_n = 1'b0;
      for (int k = 0; k < exp_q.size(); k++) begin
         @(posedge clk);
         #1;
         if (k + 1 >= hold_low) start_n = 1'b1;
         stop_n = (k == s) ? 1'b0 : 1'b1;
         @(negedge clk);
         compare(k, exp_q[k]);
      end
      start_n = 1'b1;
      stop_n  = 1'b1;
      repeat (6) @(posedge clk);
   endtask

   task automatic load_basic();
      set_entry(0, 2, 100, 1);
      set_entry(1, 3, 200, 1);
      set_entry(2, 1, 300, 1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      for (int i = 0; i < 256; i++) set_entry(i, 1, 1, 1);
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_freq", 32'(out_freq), 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_playing", 32'(is_playing), 32'd0);
      check("rst_complete", 32'(complete), 32'd0);
      check("rst_error", 32'(read_error), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // basic sequence
      load_basic();
      run(3, -1, 1);
      // empty recording
      run(0, -1, 1);
      // zero-duration skip
      set_entry(0, 2, 100, 1);
      set_entry(1, 0, 555, 1);
      set_entry(2, 3, 300, 1);
      run(3, -1, 1);
      // abort during the hold of entry 1, then replay from the start
      load_basic();
      run(3, 7, 1);
      run(3, -1, 1);
      // timeout on entry 0
      set_entry(0, 2, 100, 0);
      run(2, -1, 1);
      // start and stop together in idle: ignored, error stays set
      @(posedge clk);
      #1;
      start_n = 1'b0;
      stop_n  = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("ss_playing@%0d", k), 32'(is_playing), 32'd0);
         check($sformatf("ss_req@%0d", k), 32'(mem_req), 32'd0);
         check($sformatf("ss_error@%0d", k), 32'(read_error), 32'd1);
      end
      start_n = 1'b1;
      stop_n  = 1'b1;
      repeat (3) @(posedge clk);
      // next accepted start clears the error
      load_basic();
      run(3, -1, 1);
      // start held low for 50 cycles
      run(3, -1, 50);
      // count above the store depth is clamped
      for (int i = 0; i < 256; i++) set_entry(i, $urandom_range(0, 2), $urandom_range(1, 1023), 1);
      run(300, -1, 1);

      // randomized playbacks
      for (int it = 0; it < 15; it++) begin
         int n;
         n = $urandom_range(0, 8);
         for (int e = 0; e < n; e++)
            set_entry(e, $urandom_range(0, 6), $urandom_range(1, 1023), $urandom_range(1, 4));
         if (n > 0 && $urandom_range(0, 5) == 0) mem_lat[$urandom_range(0, n - 1)] = 0;
         run(n, -2, $urandom_range(1, 10));
      end

      // asynchronous reset in the middle of a note
      load_basic();
      entry_count = 9'd3;
      @(posedge clk);
      #1 start_n = 1'b0;
      @(posedge clk);
      #1 start_n = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      check("pre_rst_freq", 32'(out_freq), 32'd100);
      rst_n = 1'b0;
      #1;
      check("arst_freq", 32'(out_freq), 32'd0);
      check("arst_playing", 32'(is_playing), 32'd0);
      check("arst_req", 32'(mem_req), 32'd0);
      check("arst_complete", 32'(complete), 32'd0);
      check("arst_error", 32'(read_error), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_playing", 32'(is_playing), 32'd0);
      check("post_rst_freq", 32'(out_freq), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
